// File: rtl/bist_supervisor.sv
// rtl/bist_supervisor.sv - sequences per-channel BIST runs and gates core fetch on a full pass
module bist_supervisor #(
    parameter int NUM_CH         = 4,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 20,
    parameter int STOP_ON_FAIL   = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    output logic [NUM_CH-1:0] ch_start_o,
    input  logic [NUM_CH-1:0] ch_busy_i,
    input  logic [NUM_CH-1:0] ch_go_i,
    output logic              fetch_enable_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [NUM_CH-1:0] fail_mask_o,
    output logic [NUM_CH-1:0] skip_mask_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  cycles_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SC_W  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CH - 1);
    localparam logic [SC_W-1:0]  START_LAST  = SC_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("bist_supervisor: NUM_CH must be within 1..16");
    end
    if (START_CYCLES < 1) begin : g_bad_start
        $error("bist_supervisor: START_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1 ||
        (CNT_W < 63 && longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_timeout
        $error("bist_supervisor: TIMEOUT_CYCLES does not fit the CNT_W wait counter");
    end

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SC_W-1:0]   start_cnt_q, start_cnt_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              seen_busy_q, seen_busy_d;
    logic [NUM_CH-1:0] fail_q, fail_d;
    logic [NUM_CH-1:0] skip_q, skip_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              fetch_q, fetch_d;

    logic              busy_cur;
    logic              go_cur;
    logic [NUM_CH-1:0] skip_above;

    assign busy_cur = ch_busy_i[idx_q];
    assign go_cur   = ch_go_i[idx_q];

    // Channels after the current one, marked skipped when the run aborts early
    always_comb begin
        skip_above = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            skip_above[i] = (i > int'(idx_q));
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        start_cnt_d = start_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        seen_busy_d = seen_busy_q;
        fail_d      = fail_q;
        skip_d      = skip_q;
        timeout_d   = timeout_q;
        cycles_d    = cycles_q;

        if (state_q != S_IDLE && state_q != S_DONE && cycles_q != CNT_MAX) begin
            cycles_d = cycles_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d     = S_START;
                    idx_d       = '0;
                    start_cnt_d = '0;
                    wait_cnt_d  = '0;
                    seen_busy_d = 1'b0;
                    fail_d      = '0;
                    skip_d      = '0;
                    timeout_d   = 1'b0;
                    cycles_d    = '0;
                end
            end
            S_START: begin
                if (start_cnt_q == START_LAST) begin
                    state_d     = S_WAIT;
                    start_cnt_d = '0;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (busy_cur) begin
                    seen_busy_d = 1'b1;
                end
                // A busy fall on the timeout edge still counts as a real completion
                if (seen_busy_q && !busy_cur) begin
                    fail_d[idx_q] = ~go_cur;
                    state_d       = S_EVAL;
                end else if (wait_cnt_d == TIMEOUT_LIM) begin
                    fail_d[idx_q] = 1'b1;
                    timeout_d     = 1'b1;
                    state_d       = S_EVAL;
                end
            end
            S_EVAL: begin
                if (STOP_ON_FAIL != 0 && fail_q[idx_q]) begin
                    skip_d  = skip_above;
                    state_d = S_DONE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d       = idx_q + 1'b1;
                    seen_busy_d = 1'b0;
                    wait_cnt_d  = '0;
                    start_cnt_d = '0;
                    state_d     = S_START;
                end
            end
            S_DONE: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ch_start_o = '0;
        if (state_q == S_START) begin
            ch_start_o[idx_q] = 1'b1;
        end
    end

    assign done_o         = (state_q == S_DONE);
    assign pass_o         = done_o && (fail_q == '0) && (skip_q == '0);
    assign fetch_d        = pass_o;
    assign fetch_enable_o = fetch_q;
    assign fail_mask_o    = fail_q;
    assign skip_mask_o    = skip_q;
    assign timeout_o      = timeout_q;
    assign cycles_o       = cycles_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            start_cnt_q <= '0;
            wait_cnt_q  <= '0;
            seen_busy_q <= 1'b0;
            fail_q      <= '0;
            skip_q      <= '0;
            timeout_q   <= 1'b0;
            cycles_q    <= '0;
            fetch_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            start_cnt_q <= start_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            seen_busy_q <= seen_busy_d;
            fail_q      <= fail_d;
            skip_q      <= skip_d;
            timeout_q   <= timeout_d;
            cycles_q    <= cycles_d;
            fetch_q     <= fetch_d;
        end
    end

endmodule

// File: tb/tb_bist_supervisor.sv
// tb/tb_bist_supervisor.sv - timeline-model bench for two bist_supervisor builds (continue / stop-on-fail)
module tb_bist_supervisor;

    localparam int NCH = 4;
    localparam int SC  = 2;
    localparam int TO  = 100;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    logic [3:0]  start_o [2];
    logic [3:0]  busy    [2];
    logic [3:0]  go      [2];
    logic [3:0]  fail_o  [2];
    logic [3:0]  skip_o  [2];
    logic [3:0]  seen    [2];
    logic        done_o  [2];
    logic        pass_o  [2];
    logic        fetch_o [2];
    logic        to_o    [2];
    logic [19:0] cyc0;
    logic [6:0]  cyc1;

    int n_cmp = 0;
    int n_bad = 0;
    int rel = 0;
    int test_id = 0;
    bit active = 1'b0;

    // Channel behaviour: busy rises after cd WAIT cycles for cl cycles (cl==0: never), go result cg
    int cd [4];
    int cl [4];
    bit cg [4];

    int ss [2][4];
    int rr [2][4];
    bit mf [2][4];
    bit mt [2][4];
    int nrun [2];
    int endr [2];
    logic [3:0] fin_fail [2];
    logic [3:0] fin_skip [2];
    bit fin_to [2];

    int wcnt [2][4];
    bit armed [2][4];

    always #5 clk = ~clk;

    bist_supervisor #(.NUM_CH(4), .START_CYCLES(2), .TIMEOUT_CYCLES(TO), .CNT_W(20), .STOP_ON_FAIL(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .ch_start_o(start_o[0]), .ch_busy_i(busy[0]),
        .ch_go_i(go[0]), .fetch_enable_o(fetch_o[0]), .done_o(done_o[0]), .pass_o(pass_o[0]),
        .fail_mask_o(fail_o[0]), .skip_mask_o(skip_o[0]), .timeout_o(to_o[0]), .cycles_o(cyc0)
    );

    bist_supervisor #(.NUM_CH(4), .START_CYCLES(2), .TIMEOUT_CYCLES(TO), .CNT_W(7), .STOP_ON_FAIL(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .ch_start_o(start_o[1]), .ch_busy_i(busy[1]),
        .ch_go_i(go[1]), .fetch_enable_o(fetch_o[1]), .done_o(done_o[1]), .pass_o(pass_o[1]),
        .fail_mask_o(fail_o[1]), .skip_mask_o(skip_o[1]), .timeout_o(to_o[1]), .cycles_o(cyc1)
    );

    function automatic int cmax_of(input int u);
        return (u == 0) ? 1048575 : 127;
    endfunction

    function automatic logic [31:0] act_cyc(input int u);
        return (u == 0) ? {12'd0, cyc0} : {25'd0, cyc1};
    endfunction

    function automatic bit fin_pass(input int u);
        return (fin_fail[u] == 4'd0) && (fin_skip[u] == 4'd0);
    endfunction

    // Per run: edge offsets (relative to the run-start edge) of each channel's start and result
    function automatic void build_model();
        for (int u = 0; u < 2; u++) begin
            int t;
            bit stop;
            t = 0;
            stop = 1'b0;
            nrun[u] = 0;
            fin_fail[u] = 4'd0;
            fin_skip[u] = 4'd0;
            fin_to[u] = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                if (!stop) begin
                    int w;
                    int c;
                    bit f;
                    bit tm;
                    c = cd[k] + cl[k] + 1;
                    if (cl[k] == 0 || c > TO) begin
                        w = TO; f = 1'b1; tm = 1'b1;
                    end else begin
                        w = c; f = !cg[k]; tm = 1'b0;
                    end
                    ss[u][k] = t;
                    rr[u][k] = t + SC + w;
                    mf[u][k] = f;
                    mt[u][k] = tm;
                    t = rr[u][k] + 1;
                    nrun[u] = k + 1;
                    if (f) fin_fail[u][k] = 1'b1;
                    if (tm) fin_to[u] = 1'b1;
                    if (u == 1 && f) begin
                        stop = 1'b1;
                        for (int j = k + 1; j < NCH; j++) fin_skip[u][j] = 1'b1;
                    end
                end
            end
            endr[u] = t;
        end
    endfunction

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d test=%0d rel=%0d actual=%0h required=%0h", nm, u, test_id, rel, act, exp);
        end
    endtask

    task automatic compare_inst(input int u);
        logic [3:0] es, ef, ek;
        logic et, ed, ep, efe;
        int ec;
        es = 4'd0; ef = 4'd0; et = 1'b0;
        for (int k = 0; k < nrun[u]; k++) begin
            if (rel >= ss[u][k] && rel < ss[u][k] + SC) es[k] = 1'b1;
            if (rel >= rr[u][k]) begin
                ef[k] = mf[u][k];
                if (mt[u][k]) et = 1'b1;
            end
        end
        ed  = (rel >= endr[u]);
        ek  = ed ? fin_skip[u] : 4'd0;
        ep  = ed && fin_pass(u);
        efe = (rel >= endr[u] + 1) && fin_pass(u);
        ec  = (rel < endr[u]) ? rel : endr[u];
        if (ec > cmax_of(u)) ec = cmax_of(u);
        chk("ch_start", u, 32'(start_o[u]), 32'(es));
        chk("fail_mask", u, 32'(fail_o[u]), 32'(ef));
        chk("skip_mask", u, 32'(skip_o[u]), 32'(ek));
        chk("timeout", u, 32'(to_o[u]), 32'(et));
        chk("done", u, 32'(done_o[u]), 32'(ed));
        chk("pass", u, 32'(pass_o[u]), 32'(ep));
        chk("fetch_enable", u, 32'(fetch_o[u]), 32'(efe));
        chk("cycles", u, act_cyc(u), 32'(ec));
    endtask

    task automatic chk_zero(input int u);
        chk("rst_start", u, 32'(start_o[u]), 32'd0);
        chk("rst_done", u, 32'(done_o[u]), 32'd0);
        chk("rst_pass", u, 32'(pass_o[u]), 32'd0);
        chk("rst_fetch", u, 32'(fetch_o[u]), 32'd0);
        chk("rst_fail", u, 32'(fail_o[u]), 32'd0);
        chk("rst_skip", u, 32'(skip_o[u]), 32'd0);
        chk("rst_timeout", u, 32'(to_o[u]), 32'd0);
        chk("rst_cycles", u, act_cyc(u), 32'd0);
    endtask

    // Channel responders: count WAIT cycles from the fall of each channel's start
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            seen[u] = seen[u] | start_o[u];
            for (int k = 0; k < NCH; k++) begin
                if (start_o[u][k]) begin
                    armed[u][k] = 1'b1;
                    wcnt[u][k] = 0;
                    busy[u][k] = 1'b0;
                end else if (armed[u][k]) begin
                    wcnt[u][k]++;
                    busy[u][k] = (cl[k] > 0) && (wcnt[u][k] > cd[k]) && (wcnt[u][k] <= cd[k] + cl[k]);
                end else begin
                    busy[u][k] = 1'b0;
                end
                go[u][k] = busy[u][k] ? !cg[k] : cg[k];
            end
        end
    end

    always @(negedge clk) begin
        if (active) begin
            for (int u = 0; u < 2; u++) compare_inst(u);
            if (test_id == 4) begin
                if (rel == 101) chk("timeout_before_limit", 0, 32'(to_o[0]), 32'd0);
                if (rel == 102) begin
                    chk("timeout_at_limit", 0, 32'(to_o[0]), 32'd1);
                    chk("fail0_at_limit", 0, 32'(fail_o[0][0]), 32'd1);
                end
                if (rel == 103) chk("ch1_start_after_timeout", 0, 32'(start_o[0]), 32'd2);
            end
            rel++;
        end
    end

    task automatic set_all(input int d, input int l, input bit g);
        for (int k = 0; k < NCH; k++) begin
            cd[k] = d; cl[k] = l; cg[k] = g;
        end
    endtask

    task automatic clear_resp();
        for (int u = 0; u < 2; u++) begin
            seen[u] = 4'd0;
            for (int k = 0; k < NCH; k++) armed[u][k] = 1'b0;
        end
    endtask

    task automatic run_begin();
        @(negedge clk);
        en = 1'b1;
        seen[0] = 4'd0;
        seen[1] = 4'd0;
        build_model();
        @(posedge clk);
        rel = 0;
        active = 1'b1;
    endtask

    task automatic run_wait();
        int target;
        target = ((endr[0] > endr[1]) ? endr[0] : endr[1]) + 3;
        while (rel < target) begin
            @(negedge clk);
            en = (rel != 2);
        end
    endtask

    task automatic run_end();
        int ec;
        active = 1'b0;
        en = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            ec = (endr[u] > cmax_of(u)) ? cmax_of(u) : endr[u];
            chk("idle_done", u, 32'(done_o[u]), 32'd0);
            chk("idle_pass", u, 32'(pass_o[u]), 32'd0);
            chk("idle_start", u, 32'(start_o[u]), 32'd0);
            chk("hold_fail", u, 32'(fail_o[u]), 32'(fin_fail[u]));
            chk("hold_skip", u, 32'(skip_o[u]), 32'(fin_skip[u]));
            chk("hold_timeout", u, 32'(to_o[u]), 32'(fin_to[u]));
            chk("hold_cycles", u, act_cyc(u), 32'(ec));
        end
        @(negedge clk);
        for (int u = 0; u < 2; u++) chk("idle_fetch", u, 32'(fetch_o[u]), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        set_all(1, 10, 1'b1);
        for (int u = 0; u < 2; u++) begin
            busy[u] = 4'd0;
            go[u] = 4'd0;
        end
        clear_resp();
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) chk_zero(u);
        rst_n = 1'b1;

        test_id = 1;
        set_all(1, 10, 1'b1);
        run_begin(); run_wait();
        chk("allpass_cycles", 0, act_cyc(0), 32'd60);
        chk("allpass_pass", 0, 32'(pass_o[0]), 32'd1);
        chk("allpass_fetch", 0, 32'(fetch_o[0]), 32'd1);
        chk("allpass_fail", 0, 32'(fail_o[0]), 32'd0);
        run_end();

        test_id = 2;
        for (int k = 0; k < NCH; k++) begin
            cd[k] = $urandom_range(0, 3); cl[k] = $urandom_range(1, 15); cg[k] = 1'b1;
        end
        cg[2] = 1'b0;
        run_begin(); run_wait();
        chk("onefail_fail", 0, 32'(fail_o[0]), 32'h4);
        chk("onefail_skip", 0, 32'(skip_o[0]), 32'h0);
        chk("onefail_pass", 0, 32'(pass_o[0]), 32'd0);
        chk("onefail_fetch", 0, 32'(fetch_o[0]), 32'd0);
        chk("onefail_starts", 0, 32'(seen[0]), 32'hF);
        chk("onefail_sof_skip", 1, 32'(skip_o[1]), 32'h8);
        run_end();

        test_id = 3;
        set_all(1, 5, 1'b1);
        cg[1] = 1'b0;
        run_begin(); run_wait();
        chk("sof_fail", 1, 32'(fail_o[1]), 32'h2);
        chk("sof_skip", 1, 32'(skip_o[1]), 32'hC);
        chk("sof_starts", 1, 32'(seen[1]), 32'h3);
        chk("nosof_fail", 0, 32'(fail_o[0]), 32'h2);
        run_end();

        test_id = 4;
        set_all(1, 3, 1'b1);
        cd[0] = 0; cl[0] = 1000;
        run_begin(); run_wait();
        chk("stuck_timeout", 0, 32'(to_o[0]), 32'd1);
        chk("stuck_fail", 0, 32'(fail_o[0]), 32'h1);
        chk("stuck_sof_skip", 1, 32'(skip_o[1]), 32'hE);
        run_end();

        test_id = 5;
        set_all(1, 10, 1'b1);
        run_begin();
        while (rel < ss[0][1] + SC + 3) @(negedge clk);
        active = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) chk_zero(u);
        clear_resp();
        repeat (2) @(negedge clk);
        build_model();
        rst_n = 1'b1;
        @(posedge clk);
        rel = 0;
        active = 1'b1;
        run_wait();
        chk("rerun_pass", 0, 32'(pass_o[0]), 32'd1);
        chk("rerun_pass", 1, 32'(pass_o[1]), 32'd1);
        chk("rerun_cycles", 0, act_cyc(0), 32'd60);
        run_end();

        test_id = 6;
        set_all(1, 3, 1'b1);
        cl[3] = 0;
        run_begin(); run_wait();
        chk("neverbusy_fail", 0, 32'(fail_o[0]), 32'h8);
        chk("neverbusy_timeout", 0, 32'(to_o[0]), 32'd1);
        chk("neverbusy_pass", 0, 32'(pass_o[0]), 32'd0);
        run_end();

        test_id = 7;
        set_all(0, 2, 1'b1);
        cd[0] = 9;  cl[0] = 90;
        cd[1] = 10; cl[1] = 90;
        run_begin(); run_wait();
        chk("edge_fail", 0, 32'(fail_o[0]), 32'h2);
        chk("edge_timeout", 0, 32'(to_o[0]), 32'd1);
        run_end();

        test_id = 8;
        set_all(0, 60, 1'b1);
        run_begin(); run_wait();
        chk("long_cycles", 0, act_cyc(0), 32'd256);
        chk("sat_cycles", 1, act_cyc(1), 32'd127);
        chk("long_pass", 1, 32'(pass_o[1]), 32'd1);
        run_end();

        for (int it = 0; it < 10; it++) begin
            test_id = 10 + it;
            for (int k = 0; k < NCH; k++) begin
                int r;
                r = $urandom_range(0, 15);
                cd[k] = $urandom_range(0, 4);
                cl[k] = (r == 0) ? 0 : (r == 1) ? 300 : $urandom_range(1, 30);
                cg[k] = ($urandom_range(0, 7) != 0);
            end
            run_begin(); run_wait(); run_end();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
